// File: rtl/alu_share_pkg.sv
// Shared opcode and FSM state definitions for the time-shared ALU scheduler.
package alu_share_pkg;

    localparam logic [3:0] OP_OR      = 4'h0;
    localparam logic [3:0] OP_NOR     = 4'h1;
    localparam logic [3:0] OP_AND     = 4'h2;
    localparam logic [3:0] OP_NAND    = 4'h3;
    localparam logic [3:0] OP_XOR     = 4'h4;
    localparam logic [3:0] OP_XNOR    = 4'h5;
    localparam logic [3:0] OP_ADD     = 4'h6;
    localparam logic [3:0] OP_SUB     = 4'h7;
    localparam logic [3:0] OP_MUL     = 4'h8;
    localparam logic [3:0] OP_EQ      = 4'h9;
    localparam logic [3:0] OP_NEQ     = 4'hA;
    localparam logic [3:0] OP_GT      = 4'hB;
    localparam logic [3:0] OP_LT      = 4'hC;
    localparam logic [3:0] OP_GEQ     = 4'hD;
    localparam logic [3:0] OP_LEQ     = 4'hE;
    localparam logic [3:0] OP_ILLEGAL = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/alu_share_rr_pick.sv
// Round-robin priority picker: first valid requester at or after ptr_i, searching cyclically.
module alu_share_rr_pick
    import alu_share_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [1:0]      ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [1:0]      idx_o,
    output logic            any_o
);

    // Padding to four entries lets a 2-bit candidate index any NREQ without width games.
    logic [3:0] validPad;
    logic [1:0] cand;

    assign validPad = 4'(valid_i);

    always_comb begin
        idx_o = 2'd0;
        any_o = 1'b0;
        cand  = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            cand = 2'((int'(ptr_i) + k) % NREQ);
            if (!any_o && validPad[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
    end

    assign grant_o = any_o ? (NREQ'(1) << idx_o) : '0;

endmodule

// File: rtl/alu_share_sched.sv
// Round-robin scheduler time-sharing one ALU between NREQ requesters, one op in flight.
// Optional ALU_SHARE_SCHED_STATS_EN adds saturating op_count/stall_count outputs.
module alu_share_sched
    import alu_share_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int NREQ       = 2,
    parameter int MUL_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [4*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [1:0]            rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_err
`ifdef ALU_SHARE_SCHED_STATS_EN
    ,
    output logic [15:0]           op_count,
    output logic [15:0]           stall_count
`endif
);

    state_t             state_q;
    logic [1:0]         rrPtr_q;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [1:0]         id_q;
    logic [7:0]         mulCnt_q;
    logic               rspValid_q;
    logic [1:0]         rspId_q;
    logic [WIDTH-1:0]   rspData_q;
    logic               rspErr_q;

    logic [NREQ-1:0]    grant;
    logic [1:0]         winIdx;
    logic               anyValid;
    logic [WIDTH-1:0]   aluRes;
    logic               aluErr;

    alu_share_rr_pick #(.NREQ(NREQ)) u_pick (
        .valid_i (req_valid),
        .ptr_i   (rrPtr_q),
        .grant_o (grant),
        .idx_o   (winIdx),
        .any_o   (anyValid)
    );

    assign req_ready = (state_q == S_IDLE) ? grant : '0;
    assign rsp_valid = rspValid_q;
    assign rsp_id    = rspId_q;
    assign rsp_data  = rspData_q;
    assign rsp_err   = rspErr_q;

    always_comb begin
        aluRes = '0;
        aluErr = 1'b0;
        case (op_q)
            OP_OR:   aluRes = a_q | b_q;
            OP_NOR:  aluRes = ~(a_q | b_q);
            OP_AND:  aluRes = a_q & b_q;
            OP_NAND: aluRes = ~(a_q & b_q);
            OP_XOR:  aluRes = a_q ^ b_q;
            OP_XNOR: aluRes = ~(a_q ^ b_q);
            OP_ADD:  aluRes = a_q + b_q;
            OP_SUB:  aluRes = a_q - b_q;
            OP_MUL:  aluRes = a_q * b_q;
            OP_EQ:   aluRes = {{(WIDTH-1){1'b0}}, a_q == b_q};
            OP_NEQ:  aluRes = {{(WIDTH-1){1'b0}}, a_q != b_q};
            OP_GT:   aluRes = {{(WIDTH-1){1'b0}}, a_q >  b_q};
            OP_LT:   aluRes = {{(WIDTH-1){1'b0}}, a_q <  b_q};
            OP_GEQ:  aluRes = {{(WIDTH-1){1'b0}}, a_q >= b_q};
            OP_LEQ:  aluRes = {{(WIDTH-1){1'b0}}, a_q <= b_q};
            default: aluErr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rrPtr_q    <= 2'd0;
            op_q       <= 4'd0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 2'd0;
            mulCnt_q   <= 8'd0;
            rspValid_q <= 1'b0;
            rspId_q    <= 2'd0;
            rspData_q  <= '0;
            rspErr_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (anyValid) begin
                        op_q     <= req_op[4*winIdx +: 4];
                        a_q      <= req_a[WIDTH*winIdx +: WIDTH];
                        b_q      <= req_b[WIDTH*winIdx +: WIDTH];
                        id_q     <= winIdx;
                        mulCnt_q <= 8'd0;
                        state_q  <= (req_op[4*winIdx +: 4] == OP_MUL) ? S_MUL : S_EXEC;
                    end
                end
                S_EXEC: begin
                    rspData_q  <= aluRes;
                    rspErr_q   <= aluErr;
                    rspId_q    <= id_q;
                    rspValid_q <= 1'b1;
                    state_q    <= S_RESP;
                end
                S_MUL: begin
                    if (mulCnt_q == 8'(MUL_CYCLES - 1)) begin
                        rspData_q  <= aluRes;
                        rspErr_q   <= aluErr;
                        rspId_q    <= id_q;
                        rspValid_q <= 1'b1;
                        state_q    <= S_RESP;
                    end else begin
                        mulCnt_q <= mulCnt_q + 8'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rspValid_q <= 1'b0;
                        rrPtr_q    <= (rspId_q == 2'(NREQ - 1)) ? 2'd0 : rspId_q + 2'd1;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_SHARE_SCHED_STATS_EN
    logic [15:0] opCnt_q;
    logic [15:0] stallCnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opCnt_q    <= 16'd0;
            stallCnt_q <= 16'd0;
        end else if (state_q == S_RESP) begin
            if (rsp_ready && opCnt_q != 16'hFFFF)
                opCnt_q <= opCnt_q + 16'd1;
            if (!rsp_ready && stallCnt_q != 16'hFFFF)
                stallCnt_q <= stallCnt_q + 16'd1;
        end
    end

    assign op_count    = opCnt_q;
    assign stall_count = stallCnt_q;
`endif

endmodule

// File: tb/tb_alu_share_sched.sv
// Scoreboard bench for alu_share_sched: directed ops, round-robin, stall and mid-MUL reset.
// Compiled with ALU_SHARE_SCHED_STATS_EN it also checks the statistics counters.
module tb_alu_share_sched;

    localparam int WIDTH      = 4;
    localparam int NREQ       = 2;
    localparam int MUL_CYCLES = 2;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] data;
        logic       err;
    } rsp_t;

    logic             clk;
    logic             rst_n;
    logic [NREQ-1:0]  reqValid;
    logic [NREQ-1:0]  reqReady;
    logic [4*NREQ-1:0] reqOp;
    logic [WIDTH*NREQ-1:0] reqA;
    logic [WIDTH*NREQ-1:0] reqB;
    logic             rspValid;
    logic             rspReady;
    logic [1:0]       rspId;
    logic [WIDTH-1:0] rspData;
    logic             rspErr;
`ifdef ALU_SHARE_SCHED_STATS_EN
    logic [15:0]      opCount;
    logic [15:0]      stallCount;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   opsDone  = 0;
    rsp_t sbQ[$];
    rsp_t held;

    alu_share_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (reqValid),
        .req_ready   (reqReady),
        .req_op      (reqOp),
        .req_a       (reqA),
        .req_b       (reqB),
        .rsp_valid   (rspValid),
        .rsp_ready   (rspReady),
        .rsp_id      (rspId),
        .rsp_data    (rspData),
        .rsp_err     (rspErr)
`ifdef ALU_SHARE_SCHED_STATS_EN
        ,
        .op_count    (opCount),
        .stall_count (stallCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference ALU computed from the opcode table, independent of the DUT.
    function automatic rsp_t modelAlu(input logic [1:0] id, input logic [3:0] op,
                                      input logic [3:0] a, input logic [3:0] b);
        rsp_t r;
        logic [7:0] wide;
        r.id   = id;
        r.err  = 1'b0;
        r.data = 4'd0;
        case (op)
            4'h0: r.data = a | b;
            4'h1: r.data = ~(a | b);
            4'h2: r.data = a & b;
            4'h3: r.data = ~(a & b);
            4'h4: r.data = a ^ b;
            4'h5: r.data = ~(a ^ b);
            4'h6: begin wide = 8'(a) + 8'(b); r.data = wide[3:0]; end
            4'h7: begin wide = 8'(a) + 8'd16 - 8'(b); r.data = wide[3:0]; end
            4'h8: begin wide = 8'(a) * 8'(b); r.data = wide[3:0]; end
            4'h9: r.data = (a == b) ? 4'd1 : 4'd0;
            4'hA: r.data = (a != b) ? 4'd1 : 4'd0;
            4'hB: r.data = (a >  b) ? 4'd1 : 4'd0;
            4'hC: r.data = (a <  b) ? 4'd1 : 4'd0;
            4'hD: r.data = (a >= b) ? 4'd1 : 4'd0;
            4'hE: r.data = (a <= b) ? 4'd1 : 4'd0;
            default: begin r.data = 4'd0; r.err = 1'b1; end
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int id, input logic [3:0] op,
                                 input logic [3:0] a, input logic [3:0] b);
        reqValid[id]      = 1'b1;
        reqOp[4*id +: 4]  = op;
        reqA[4*id +: 4]   = a;
        reqB[4*id +: 4]   = b;
    endtask

    // Wait (bounded) for rsp_valid, check latency, then pop and compare one scoreboard entry.
    task automatic waitResponse(input int expLat, input string tag);
        int lat = 1;
        rsp_t exp;
        while (!rspValid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, "_pending"}, 32'(sbQ.size() != 0), 32'd1);
        if (rspValid && sbQ.size() != 0) begin
            exp = sbQ.pop_front();
            checkOutput({tag, "_id"},   32'(rspId),   32'(exp.id));
            checkOutput({tag, "_data"}, 32'(rspData), 32'(exp.data));
            checkOutput({tag, "_err"},  32'(rspErr),  32'(exp.err));
            if (rspReady) opsDone++;
        end
    endtask

    // Single requester op from an IDLE negedge through to response retirement.
    task automatic runOp(input int id, input logic [3:0] op, input logic [3:0] a,
                         input logic [3:0] b, input string tag);
        applyStimulus(id, op, a, b);
        rspReady = 1'b1;
        #1;
        checkOutput({tag, "_grant"}, 32'(reqReady), 32'(2'b01 << id));
        sbQ.push_back(modelAlu(2'(id), op, a, b));
        @(negedge clk);
        reqValid = '0;
        waitResponse((op == 4'h8) ? 1 + MUL_CYCLES : 2, tag);
        @(negedge clk);
        checkOutput({tag, "_drop"}, 32'(rspValid), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        reqValid = '0;
        reqOp    = '0;
        reqA     = '0;
        reqB     = '0;
        rspReady = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_valid", 32'(rspValid), 32'd0);
        checkOutput("reset_id",    32'(rspId),    32'd0);
        checkOutput("reset_data",  32'(rspData),  32'd0);
        checkOutput("reset_err",   32'(rspErr),   32'd0);
        checkOutput("reset_ready", 32'(reqReady), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] basic add and multi-cycle mul");
        runOp(0, 4'h6, 4'd9, 4'd9, "add");
        runOp(1, 4'h8, 4'd7, 4'd3, "mul");

        $display("[TB] round robin with both requesters valid");
        applyStimulus(0, 4'hB, 4'd5, 4'd3);
        applyStimulus(1, 4'hB, 4'd5, 4'd3);
        rspReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("rr_grant", 32'(reqReady), 32'((k % 2 == 0) ? 2'b01 : 2'b10));
            sbQ.push_back(modelAlu(2'(k % 2), 4'hB, 4'd5, 4'd3));
            @(negedge clk);
            checkOutput("rr_busy_ready", 32'(reqReady), 32'd0);
            waitResponse(2, "rr");
            @(negedge clk);
        end
        reqValid = '0;

        $display("[TB] opcode table");
        runOp(1, 4'hF, 4'd3, 4'd4, "illegal");
        runOp(0, 4'h4, 4'hC, 4'hA, "xor");
        runOp(1, 4'h7, 4'd2, 4'd5, "sub_wrap");
        runOp(0, 4'hE, 4'd7, 4'd7, "leq_equal");
        runOp(1, 4'h3, 4'hF, 4'hF, "nand");
        runOp(0, 4'h8, 4'hF, 4'hF, "mul_max");
        runOp(1, 4'hD, 4'd2, 4'd9, "geq");
        runOp(0, 4'h1, 4'd0, 4'd0, "nor");

        $display("[TB] response backpressure");
        applyStimulus(0, 4'h5, 4'hA, 4'h5);
        rspReady = 1'b0;
        #1;
        checkOutput("stall_grant", 32'(reqReady), 32'd1);
        sbQ.push_back(modelAlu(2'd0, 4'h5, 4'hA, 4'h5));
        held = sbQ[0];
        @(negedge clk);
        reqValid = 2'b10;
        begin
            int lat = 1;
            while (!rspValid && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            checkOutput("stall_latency", 32'(lat), 32'd2);
        end
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_valid", 32'(rspValid), 32'd1);
            checkOutput("stall_data",  32'(rspData),  32'(held.data));
            checkOutput("stall_id",    32'(rspId),    32'(held.id));
            checkOutput("stall_ready", 32'(reqReady), 32'd0);
            @(negedge clk);
        end
`ifdef ALU_SHARE_SCHED_STATS_EN
        checkOutput("stall_count", 32'(stallCount), 32'd5);
`endif
        reqValid = '0;
        rspReady = 1'b1;
        waitResponse(1, "stall_release");
        @(negedge clk);
        checkOutput("stall_drop", 32'(rspValid), 32'd0);
`ifdef ALU_SHARE_SCHED_STATS_EN
        checkOutput("op_count", 32'(opCount), 32'(opsDone));
`endif

        $display("[TB] reset during multiply");
        applyStimulus(0, 4'h8, 4'd3, 4'd3);
        #1;
        checkOutput("rst_mul_grant", 32'(reqReady), 32'd1);
        @(negedge clk);
        reqValid = '0;
        rst_n    = 1'b0;
        #1;
        checkOutput("rst_valid_now", 32'(rspValid), 32'd0);
        @(negedge clk);
        checkOutput("rst_valid_next", 32'(rspValid), 32'd0);
        rst_n = 1'b1;
        applyStimulus(0, 4'h6, 4'd1, 4'd2);
        applyStimulus(1, 4'h6, 4'd3, 4'd4);
        #1;
        checkOutput("post_rst_grant", 32'(reqReady), 32'd1);
        sbQ.push_back(modelAlu(2'd0, 4'h6, 4'd1, 4'd2));
        @(negedge clk);
        reqValid = '0;
        waitResponse(2, "post_rst");
        @(negedge clk);
        checkOutput("post_rst_drop", 32'(rspValid), 32'd0);
`ifdef ALU_SHARE_SCHED_STATS_EN
        checkOutput("op_count_after_rst", 32'(opCount), 32'd1);
`endif
        checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
